// File: rtl/uart_frame_assembler_pkg.sv
// rtl/uart_frame_assembler_pkg.sv - shared state encoding and defaults for the UART frame path
package uart_frame_assembler_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } fa_state_t;

    // Default inter-byte idle limit in sys_clk cycles.
    localparam int DEFAULT_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/uart_frame_assembler_if.sv
// rtl/uart_frame_assembler_if.sv - byte strobe bundle from the UART RX byte stage
// Signals:
//   rx_byte  - received byte
//   rx_valid - one-cycle strobe, rx_byte valid
//   rx_err   - one-cycle strobe, framing/parity error on current byte
// master drives the bundle (RX byte stage), slave consumes it (frame assembler).
interface uart_frame_assembler_if;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    modport master (output rx_byte, output rx_valid, output rx_err);
    modport slave  (input  rx_byte, input  rx_valid, input  rx_err);

endinterface

// File: rtl/uart_timeout_counter.sv
// rtl/uart_timeout_counter.sv - saturating idle-cycle counter with expiry flag
// Ports:
//   sys_clk - clock, rising edge
//   rst     - synchronous active-high reset
//   clear   - zero the count (dominates enable)
//   enable  - count this cycle as idle
//   expire  - this enabled cycle is the TIMEOUT_CYC-th consecutive idle cycle
module uart_timeout_counter
    import uart_frame_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the idle cycles already elapsed, so the current enabled
    // cycle is the last allowed one when cnt has reached TIMEOUT_CYC-1.
    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - assembles BRN received UART bytes into one frame
// Ports:
//   sys_clk        - clock, rising edge
//   rst            - synchronous active-high reset
//   rx             - byte strobe bundle (rx_byte, rx_valid, rx_err)
//   dataR          - last complete frame, first byte in the top byte
//   uart_recv_flag - one-cycle pulse, new frame on dataR
//   frame_err      - one-cycle pulse, partial frame discarded
//   byte_cnt       - bytes collected in the current frame
module uart_frame_assembler
    import uart_frame_assembler_pkg::*;
#(
    parameter int BRN         = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    uart_frame_assembler_if.slave      rx,
    output logic [BRN*8-1:0]           dataR,
    output logic                       uart_recv_flag,
    output logic                       frame_err,
    output logic [$clog2(BRN+1)-1:0]   byte_cnt
);

    localparam int CNT_W = $clog2(BRN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BRN - 1);
    // Only the first BRN-1 bytes need holding; the completing byte goes
    // straight into dataR. A one-byte frame keeps a dummy byte of storage.
    localparam int SHW = (BRN > 1) ? (BRN - 1) * 8 : 8;

    fa_state_t        state;
    logic [SHW-1:0]   shift_q;
    logic [BRN*8-1:0] frame_d;
    logic             expire;

    generate
        if (BRN > 1) begin : g_multi
            assign frame_d = {shift_q, rx.rx_byte};
        end else begin : g_single
            assign frame_d = rx.rx_byte;
        end
    endgenerate

    uart_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   ((state != ST_COLLECT) || rx.rx_valid || rx.rx_err),
        .enable  ((state == ST_COLLECT) && !rx.rx_valid),
        .expire  (expire)
    );

    // Priority: error strobe, then byte acceptance, then timeout, so a byte
    // landing on the expiry cycle wins and flag/err can never coincide.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            shift_q        <= '0;
            dataR          <= '0;
            uart_recv_flag <= 1'b0;
            frame_err      <= 1'b0;
            byte_cnt       <= '0;
        end else begin
            uart_recv_flag <= 1'b0;
            frame_err      <= 1'b0;
            if (rx.rx_err) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
                byte_cnt  <= '0;
                shift_q   <= '0;
            end else if (rx.rx_valid) begin
                if (byte_cnt == LAST_CNT) begin
                    dataR          <= frame_d;
                    uart_recv_flag <= 1'b1;
                    state          <= ST_IDLE;
                    byte_cnt       <= '0;
                    shift_q        <= '0;
                end else begin
                    shift_q  <= frame_d[SHW-1:0];
                    byte_cnt <= byte_cnt + 1'b1;
                    state    <= ST_COLLECT;
                end
            end else if ((state == ST_COLLECT) && expire) begin
                frame_err <= 1'b1;
                state     <= ST_IDLE;
                byte_cnt  <= '0;
                shift_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb/tb_uart_frame_assembler.sv - scoreboard bench for uart_frame_assembler
module tb_uart_frame_assembler;

    localparam int BRN = 4;
    localparam int TO  = 20;

    typedef struct {
        bit          is_frame;
        logic [31:0] data;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [31:0] dataR;
    logic        uart_recv_flag;
    logic        frame_err;
    logic [2:0]  byte_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    uart_frame_assembler_if rx_if ();

    uart_frame_assembler #(
        .BRN         (BRN),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .rx             (rx_if),
        .dataR          (dataR),
        .uart_recv_flag (uart_recv_flag),
        .frame_err      (frame_err),
        .byte_cnt       (byte_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] d);
        exp_t e;
        e.is_frame = 1'b1;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_frame = 1'b0;
        e.data     = '0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_byte  = b;
        rx_if.rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (uart_recv_flag || frame_err) begin
                chk("flag_err_exclusive", {31'd0, uart_recv_flag & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got flag=%0b err=%0b want none", uart_recv_flag, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", {30'd0, uart_recv_flag, frame_err},
                        e.is_frame ? 32'd2 : 32'd1);
                    if (e.is_frame && uart_recv_flag)
                        chk("frame_data", dataR, e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        rx_if.rx_byte  = 8'hFF;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_err   = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_dataR", dataR, 32'h0);
        chk("reset_flag", {31'd0, uart_recv_flag}, 32'd0);
        chk("reset_err", {31'd0, frame_err}, 32'd0);
        chk("reset_cnt", {29'd0, byte_cnt}, 32'd0);
        rst            = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_err   = 1'b0;
        idle(2);

        // "RD00" with 10-cycle spacing
        send_byte(8'h52); idle(9);
        send_byte(8'h44); idle(9);
        send_byte(8'h30); idle(9);
        chk("rd00_cnt3", {29'd0, byte_cnt}, 32'd3);
        chk("rd00_dataR_hold", dataR, 32'h0);
        push_frame(32'h52443030);
        send_byte(8'h30);
        chk("rd00_flag", {31'd0, uart_recv_flag}, 32'd1);
        chk("rd00_dataR", dataR, 32'h52443030);
        chk("rd00_cnt0", {29'd0, byte_cnt}, 32'd0);
        idle(1);
        chk("rd00_flag_width", {31'd0, uart_recv_flag}, 32'd0);
        chk("rd00_dataR_keep", dataR, 32'h52443030);

        // Timeout after two bytes
        send_byte(8'h01);
        send_byte(8'h02);
        chk("to_cnt2", {29'd0, byte_cnt}, 32'd2);
        push_err();
        idle(TO - 1);
        chk("to_not_early", {31'd0, frame_err}, 32'd0);
        chk("to_cnt_hold", {29'd0, byte_cnt}, 32'd2);
        idle(1);
        chk("to_err", {31'd0, frame_err}, 32'd1);
        chk("to_cnt0", {29'd0, byte_cnt}, 32'd0);
        chk("to_dataR", dataR, 32'h52443030);
        idle(3);

        // rx_err on fourth byte, then rx_err in IDLE, then clean frame
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        push_err();
        rx_if.rx_byte  = 8'h0D;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_err   = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_err   = 1'b0;
        chk("rxerr_err", {31'd0, frame_err}, 32'd1);
        chk("rxerr_noflag", {31'd0, uart_recv_flag}, 32'd0);
        chk("rxerr_cnt0", {29'd0, byte_cnt}, 32'd0);
        chk("rxerr_dataR", dataR, 32'h52443030);
        idle(2);
        push_err();
        rx_if.rx_err = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_if.rx_err = 1'b0;
        chk("idle_err", {31'd0, frame_err}, 32'd1);
        chk("idle_err_cnt", {29'd0, byte_cnt}, 32'd0);
        idle(2);
        push_frame(32'h11223344);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("after_err_dataR", dataR, 32'h11223344);
        idle(3);

        // Back-to-back frames, next frame's first byte on the flag cycle
        push_frame(32'hA1A2A3A4);
        push_frame(32'hAABBCCDD);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        chk("b2b_flag1", {31'd0, uart_recv_flag}, 32'd1);
        send_byte(8'hAA);
        chk("b2b_cnt1", {29'd0, byte_cnt}, 32'd1);
        chk("b2b_dataR1", dataR, 32'hA1A2A3A4);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("b2b_flag2", {31'd0, uart_recv_flag}, 32'd1);
        chk("b2b_dataR2", dataR, 32'hAABBCCDD);
        idle(3);

        // Reset mid-frame with a byte strobe during reset
        send_byte(8'h01);
        send_byte(8'h02);
        rst            = 1'b1;
        rx_if.rx_byte  = 8'h77;
        rx_if.rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rst            = 1'b0;
        rx_if.rx_valid = 1'b0;
        chk("rst_dataR", dataR, 32'h0);
        chk("rst_cnt", {29'd0, byte_cnt}, 32'd0);
        chk("rst_flag", {31'd0, uart_recv_flag}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        idle(2);
        chk("rst_no_err", {31'd0, frame_err}, 32'd0);
        push_frame(32'h5AA53CC3);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hC3);
        chk("rst_frame", dataR, 32'h5AA53CC3);
        idle(3);

        // Byte on the exact expiry cycle is accepted
        push_frame(32'h10203040);
        send_byte(8'h10);
        idle(TO - 1);
        send_byte(8'h20);
        chk("edge_cnt2", {29'd0, byte_cnt}, 32'd2);
        chk("edge_no_err", {31'd0, frame_err}, 32'd0);
        idle(1);
        chk("edge_no_err2", {31'd0, frame_err}, 32'd0);
        send_byte(8'h30);
        send_byte(8'h40);
        chk("edge_frame", dataR, 32'h10203040);
        idle(5);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 Parameter BRN, default 4, frame length in bytes; must be at least 1.
REQ-002 Parameter TIMEOUT_CYC, default 50000, maximum idle sys_clk cycles allowed between bytes of one frame; must be at least 1.
REQ-003 sys_clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_byte  input  8  received byte from byte-level UART RX.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_byte valid.
REQ-007 rx_err  input  1  one-cycle strobe, framing/parity error on current byte.
REQ-008 dataR  output  BRN*8  last complete frame, registered; feeds protocol stage.
REQ-009 uart_recv_flag  output  1  one-cycle pulse, new frame valid on dataR.
REQ-010 frame_err  output  1  one-cycle pulse, partial frame discarded.
REQ-011 byte_cnt  output  $clog2(BRN+1)  bytes collected in current frame.

Function
REQ-012 States: IDLE (byte_cnt=0, no frame in progress) and COLLECT (0<byte_cnt<BRN).
REQ-013 IDLE, rx_valid=1, rx_err=0: shift byte in, byte_cnt=1, go to COLLECT; if BRN=1, complete the frame instead (REQ-015).
REQ-014 COLLECT, rx_valid=1, rx_err=0: shift byte in, byte_cnt+1, clear timeout counter.
REQ-015 Completing byte (byte_cnt reaches BRN): next cycle, dataR = assembled frame and uart_recv_flag=1 for exactly one cycle; byte_cnt=0; state IDLE.
REQ-016 Byte order: first received byte occupies dataR[BRN*8-1 -: 8], last byte dataR[7:0] (ASCII "RD00" arrives R,D,0,0).
REQ-017 Shift register separate from dataR; dataR changes only on frame completion and holds otherwise.
REQ-018 A byte arriving in the cycle uart_recv_flag is high is accepted as byte 1 of the next frame; no dead cycle.
REQ-019 rx_err=1 (with or without rx_valid): byte not accepted; in COLLECT, discard partial frame, frame_err pulse next cycle, IDLE; in IDLE, frame_err pulse, stay IDLE.
REQ-020 Timeout counter runs in COLLECT only, cleared on each accepted byte; at TIMEOUT_CYC consecutive cycles without rx_valid: discard, frame_err pulse, byte_cnt=0, IDLE.
REQ-021 Timeout expiry and rx_valid in same cycle: byte accepted, timeout ignored.
REQ-022 uart_recv_flag and frame_err never high in the same cycle.
REQ-023 Timeout counter width $clog2(TIMEOUT_CYC+1); saturates, never wraps.

Reset
REQ-024 rst=1 at a clock edge: dataR=0, uart_recv_flag=0, frame_err=0, byte_cnt=0, shift register=0, timeout counter=0, state IDLE.
REQ-025 Reset mid-frame discards partial frame silently; no frame_err pulse.
REQ-026 Inputs ignored in any cycle with rst=1.

Structure
REQ-027 Shared package holds state encoding (IDLE, COLLECT) and default TIMEOUT_CYC constant.
REQ-028 One sub-module natural: uart_timeout_counter (clear, enable, expire output), reused by later UART stages.
REQ-029 Single always block per register group; no async or multi-edge sensitivity.

Verification
REQ-030 BRN=4, bytes 0x52,0x44,0x30,0x30 spaced 10 cycles -> one cycle after 4th strobe dataR=0x52443030, uart_recv_flag pulse of width 1.
REQ-031 Two bytes, then idle TIMEOUT_CYC cycles (bench TIMEOUT_CYC=20) -> frame_err pulse at cycle 20, byte_cnt=0, dataR unchanged.
REQ-032 Three bytes, rx_err on 4th -> frame_err pulse, no uart_recv_flag; next 4 clean bytes 0x11..0x44 -> dataR=0x11223344.
REQ-033 Back-to-back frames, 5th byte 0xAA on the flag cycle -> accepted, byte_cnt=1, second frame completes correctly.
REQ-034 rst asserted after 2 bytes -> all outputs 0, no frame_err; following 4-byte frame assembled correctly.
REQ-035 rx_valid on the exact timeout-expiry cycle -> byte accepted, no frame_err, byte_cnt increments.
